// File: rtl/duck_io_pkg.sv
// Shared types and helpers for the GPIO cursor link (transmit side).
package duck_io_pkg;

  localparam int COORD_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    X_SETUP,
    X_STROBE,
    X_GAP,
    Y_SETUP,
    Y_STROBE,
    Y_GAP
  } tx_state_t;

  // Even parity bit over the select line and the data word.
  function automatic logic word_parity(input logic sel, input logic [COORD_W-1:0] data);
    return ^{sel, data};
  endfunction

  // Clamp a coordinate to its upper limit.
  function automatic logic [COORD_W-1:0] sat_coord(input logic [COORD_W-1:0] value,
                                                   input logic [COORD_W-1:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Rising-edge triggered, non-retriggerable pulse of exactly LEN cycles.
module pulse_stretcher #(
  parameter int LEN = 500000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic trig,
  output logic pulse_out
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LEN_LD = CNT_W'(LEN);

  logic             trig_q;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign rise = trig & ~trig_q;

  // Edges are only honoured once the previous pulse has fully expired.
  always_comb begin
    cnt_nxt = cnt;
    if (cnt != '0) begin
      cnt_nxt = cnt - CNT_W'(1);
    end else if (rise) begin
      cnt_nxt = LEN_LD;
    end
  end

  // Edge register, remaining-length counter and the registered pulse level.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      trig_q    <= 1'b0;
      cnt       <= '0;
      pulse_out <= 1'b0;
    end else begin
      trig_q    <= trig;
      cnt       <= cnt_nxt;
      pulse_out <= (cnt_nxt != '0);
    end
  end

endmodule

// File: rtl/coord_transmitter.sv
// Serialises a captured (x,y) cursor position as two strobed words on the GPIO header,
// plus an independent stretched shot level.
module coord_transmitter
  import duck_io_pkg::*;
#(
  parameter int SETUP_CYC  = 4,
  parameter int STROBE_CYC = 8,
  parameter int GAP_CYC    = 4,
  parameter int SHOT_CYC   = 500000,
  parameter int X_MAX      = 319,
  parameter int Y_MAX      = 479
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic               load,
  output logic               ready,
  input  logic               trigger,
  output logic               frame_done,
  output logic [COORD_W-1:0] gpio_data,
  output logic               gpio_sel,
  output logic               gpio_parity,
  output logic               gpio_strobe,
  output logic               gpio_shot
);

  localparam int PH_MAX = (SETUP_CYC > STROBE_CYC)
                          ? ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC)
                          : ((STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC);
  localparam int PH_W = $clog2(PH_MAX + 1);

  // Counter reload values: a phase of length L counts L-1 down to 0.
  localparam logic [PH_W-1:0] SETUP_LD  = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0] STROBE_LD = PH_W'(STROBE_CYC - 1);
  localparam logic [PH_W-1:0] GAP_LD    = PH_W'(GAP_CYC - 1);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_MAX);

  tx_state_t          state;
  tx_state_t          state_nxt;
  logic [PH_W-1:0]    ph_cnt;
  logic [PH_W-1:0]    ph_cnt_nxt;
  logic [COORD_W-1:0] x_sat;
  logic [COORD_W-1:0] y_sat;
  logic [COORD_W-1:0] x_sat_nxt;
  logic [COORD_W-1:0] y_sat_nxt;
  logic [COORD_W-1:0] data_nxt;
  logic               sel_nxt;
  logic               strobe_nxt;
  logic               done_nxt;
  logic               accept;

  assign accept = load && ready;

  // Next state and phase counter: each phase counts down and reloads on entry to the next.
  always_comb begin
    state_nxt  = state;
    ph_cnt_nxt = ph_cnt;
    if (state != IDLE && ph_cnt != '0) begin
      ph_cnt_nxt = ph_cnt - PH_W'(1);
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_nxt  = X_SETUP;
            ph_cnt_nxt = SETUP_LD;
          end
        end
        X_SETUP: begin
          state_nxt  = X_STROBE;
          ph_cnt_nxt = STROBE_LD;
        end
        X_STROBE: begin
          state_nxt  = X_GAP;
          ph_cnt_nxt = GAP_LD;
        end
        X_GAP: begin
          state_nxt  = Y_SETUP;
          ph_cnt_nxt = SETUP_LD;
        end
        Y_SETUP: begin
          state_nxt  = Y_STROBE;
          ph_cnt_nxt = STROBE_LD;
        end
        Y_STROBE: begin
          state_nxt  = Y_GAP;
          ph_cnt_nxt = GAP_LD;
        end
        Y_GAP: begin
          state_nxt  = IDLE;
          ph_cnt_nxt = '0;
        end
        default: begin
          state_nxt  = IDLE;
          ph_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Pin values for the coming cycle; on accept the freshly clamped inputs go straight out.
  always_comb begin
    x_sat_nxt  = accept ? sat_coord(x_in, X_LIM) : x_sat;
    y_sat_nxt  = accept ? sat_coord(y_in, Y_LIM) : y_sat;
    sel_nxt    = (state_nxt == Y_SETUP) || (state_nxt == Y_STROBE) || (state_nxt == Y_GAP);
    strobe_nxt = (state_nxt == X_STROBE) || (state_nxt == Y_STROBE);
    done_nxt   = (state_nxt == Y_GAP) && (ph_cnt_nxt == '0);
    if (state_nxt == IDLE) begin
      data_nxt = '0;
    end else if (sel_nxt) begin
      data_nxt = y_sat_nxt;
    end else begin
      data_nxt = x_sat_nxt;
    end
  end

  // Frame FSM with all pin outputs registered alongside the state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      ph_cnt      <= '0;
      x_sat       <= '0;
      y_sat       <= '0;
      ready       <= 1'b1;
      frame_done  <= 1'b0;
      gpio_data   <= '0;
      gpio_sel    <= 1'b0;
      gpio_parity <= 1'b0;
      gpio_strobe <= 1'b0;
    end else begin
      state       <= state_nxt;
      ph_cnt      <= ph_cnt_nxt;
      x_sat       <= x_sat_nxt;
      y_sat       <= y_sat_nxt;
      ready       <= (state_nxt == IDLE);
      frame_done  <= done_nxt;
      gpio_data   <= data_nxt;
      gpio_sel    <= sel_nxt;
      gpio_parity <= word_parity(sel_nxt, data_nxt);
      gpio_strobe <= strobe_nxt;
    end
  end

  pulse_stretcher #(
    .LEN(SHOT_CYC)
  ) u_shot (
    .Clk      (Clk),
    .Reset    (Reset),
    .trig     (trigger),
    .pulse_out(gpio_shot)
  );

endmodule

// File: tb/tb_coord_transmitter.sv
module tb_coord_transmitter;

  localparam int S    = 4;
  localparam int ST   = 8;
  localparam int G    = 4;
  localparam int H    = S + ST + G;
  localparam int F    = 2 * H;
  localparam int SHOT = 10;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [8:0] x_in, y_in;
  logic       load, trigger;
  logic       ready, frame_done;
  logic [8:0] gpio_data;
  logic       gpio_sel, gpio_parity, gpio_strobe, gpio_shot;

  coord_transmitter #(
    .SETUP_CYC (S),
    .STROBE_CYC(ST),
    .GAP_CYC   (G),
    .SHOT_CYC  (SHOT),
    .X_MAX     (319),
    .Y_MAX     (479)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .x_in       (x_in),
    .y_in       (y_in),
    .load       (load),
    .ready      (ready),
    .trigger    (trigger),
    .frame_done (frame_done),
    .gpio_data  (gpio_data),
    .gpio_sel   (gpio_sel),
    .gpio_parity(gpio_parity),
    .gpio_strobe(gpio_strobe),
    .gpio_shot  (gpio_shot)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: m_t is the cycle offset since the accepting edge (0 = idle).
  int   m_t, m_x, m_y, m_shot;
  logic m_trig_prev;
  int   cyc, done_seen, strobe_rises;
  logic strobe_prev;

  typedef struct {
    logic [8:0] x;
    logic [8:0] y;
    int         ex;
    int         ey;
  } sat_vec_t;

  sat_vec_t tbl [6];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_t = 0; m_x = 0; m_y = 0; m_shot = 0; m_trig_prev = 1'b0; strobe_prev = 1'b0;
  endtask

  task automatic model_update();
    logic e;
    if (m_t == 0) begin
      if (load) begin
        m_t = 1;
        m_x = clamp(int'(x_in), 319);
        m_y = clamp(int'(y_in), 479);
      end
    end else if (m_t == F) begin
      m_t = 0;
    end else begin
      m_t++;
    end
    e = trigger && !m_trig_prev;
    m_trig_prev = trigger;
    if (m_shot > 0) m_shot--;
    else if (e) m_shot = SHOT;
  endtask

  task automatic check_outputs();
    int   e_data;
    logic e_sel, e_strobe;
    e_sel    = (m_t > H);
    e_strobe = (m_t >= S + 1 && m_t <= S + ST) || (m_t >= H + S + 1 && m_t <= H + S + ST);
    e_data   = (m_t == 0) ? 0 : (e_sel ? m_y : m_x);
    check("ready", int'(ready), int'(m_t == 0));
    check("frame_done", int'(frame_done), int'(m_t == F));
    check("gpio_data", int'(gpio_data), e_data);
    check("gpio_sel", int'(gpio_sel), int'(e_sel));
    check("gpio_strobe", int'(gpio_strobe), int'(e_strobe));
    check("gpio_parity", int'(gpio_parity), int'(^{e_sel, 9'(e_data)}));
    check("gpio_shot", int'(gpio_shot), int'(m_shot > 0));
  endtask

  task automatic step();
    @(posedge Clk);
    model_update();
    #1;
    cyc++;
    check_outputs();
    if (gpio_strobe && !strobe_prev) strobe_rises++;
    strobe_prev = gpio_strobe;
    if (frame_done) done_seen++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_done, n1, n2, budget;
    tbl[0] = '{9'h0A5, 9'h1C2, 'h0A5, 'h1C2};
    tbl[1] = '{9'd511, 9'd500, 319, 479};
    tbl[2] = '{9'd319, 9'd479, 319, 479};
    tbl[3] = '{9'd320, 9'd480, 319, 479};
    tbl[4] = '{9'd0,   9'd0,   0,   0};
    tbl[5] = '{9'd1,   9'd478, 1,   478};

    Reset = 1'b1; load = 1'b0; trigger = 1'b0; x_in = '0; y_in = '0;
    cyc = 0; done_seen = 0; strobe_rises = 0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check_outputs();
    Reset = 1'b0;

    // Idle: no activity for 100 cycles with load low.
    strobe_rises = 0;
    repeat (100) step();
    check("idle_strobes", strobe_rises, 0);

    // Table-driven frames, including saturation and an ignored mid-frame load.
    foreach (tbl[i]) begin
      done_seen = 0;
      x_in = tbl[i].x; y_in = tbl[i].y; load = 1'b1;
      step();
      load = 1'b0;
      x_in = 9'($urandom_range(0, 511)); y_in = 9'($urandom_range(0, 511));
      for (int k = 2; k <= F + 1; k++) begin
        load = (k >= 10 && k <= 12);
        step();
        if (m_t == S + 1)     check("x_word", int'(gpio_data), tbl[i].ex);
        if (m_t == H + S + 1) check("y_word", int'(gpio_data), tbl[i].ey);
      end
      load = 1'b0;
      check("frames_sent", done_seen, 1);
      check("ready_after", int'(ready), 1);
    end

    // Back-to-back: load held for three frames.
    done_seen = 0; strobe_rises = 0; last_done = -1; budget = 0;
    x_in = 9'd100; y_in = 9'd200; load = 1'b1;
    while (done_seen < 3 && budget < 200) begin
      step();
      budget++;
      if (frame_done) begin
        if (last_done >= 0) check("b2b_period", cyc - last_done, F + 1);
        last_done = cyc;
      end
    end
    load = 1'b0;
    check("b2b_frames", done_seen, 3);
    check("b2b_strobes", strobe_rises, 6);
    repeat (3) step();

    // Shot: pulses at 1, 4 (ignored) and 12 (new shot), with a concurrent frame.
    n1 = 0; n2 = 0;
    x_in = 9'd77; y_in = 9'd300;
    for (int j = 1; j <= 40; j++) begin
      trigger = (j == 1 || j == 4 || j == 12);
      load = (j == 1);
      step();
      if (j <= 11) n1 += int'(gpio_shot);
      else n2 += int'(gpio_shot);
    end
    trigger = 1'b0;
    check("shot1_len", n1, SHOT);
    check("shot2_len", n2, SHOT);

    // Reset during Y_STROBE while a shot is running.
    done_seen = 0;
    load = 1'b1; trigger = 1'b1;
    step();
    load = 1'b0; trigger = 1'b0;
    budget = 0;
    while (m_t != H + S + 3 && budget < 60) begin
      step();
      budget++;
    end
    check("reached_y_strobe", m_t, H + S + 3);
    #1 Reset = 1'b1;
    #1;
    check("rst_strobe", int'(gpio_strobe), 0);
    check("rst_shot", int'(gpio_shot), 0);
    check("rst_ready", int'(ready), 1);
    check("rst_data", int'(gpio_data), 0);
    repeat (2) @(posedge Clk);
    model_reset();
    #1 Reset = 1'b0;
    repeat (40) step();
    check("no_done_after_reset", done_seen, 0);
    x_in = 9'h123; y_in = 9'h0F0; load = 1'b1;
    step();
    load = 1'b0;
    repeat (F) step();
    check("frame_after_reset", done_seen, 1);

    // Randomised traffic against the model.
    for (int r = 0; r < 3000; r++) begin
      load = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) trigger = ~trigger;
      x_in = 9'($urandom_range(0, 511));
      y_in = 9'($urandom_range(0, 511));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
